present_iter_core: RTL
======================

# present_iter_core

Iterative PRESENT block-cipher core, one round per clock, parametrised for 80- or 128-bit keys and a configurable round count, supporting both encryption and decryption. It replaces the fixed 80-bit, encrypt-only datapath-plus-controller arrangement with a single self-sequenced engine behind a start/done handshake. It sits between the host register interface, which supplies key and text, and the result capture logic.

## Interface
- KEY_W, 80, key width; legal values 80 or 128 only; any other value is an elaboration error.
- ROUNDS, 31, number of S-box/permutation rounds; legal 1..31, with a 5-bit round constant.
- clk  in  1  clock; all state updates occur on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only while ready=1.
- decrypt  in  1  mode, sampled with start: 0 = encrypt, 1 = decrypt.
- key_in  in  KEY_W  cipher key K; sampled with start.
- text_in  in  64  plaintext or ciphertext; sampled with start.
- ready  out  1  high in IDLE; reset value 1.
- busy  out  1  equals ~ready; reset value 0.
- done  out  1  one-cycle pulse when text_out updates; reset value 0.
- text_out  out  64  result; holds its value until the next done; reset value 0.

## Operation
- Internal registers: state (64 bits), key (KEY_W bits), rc (5 bits), FSM.
- FSM states: IDLE, KEYEXP, EROUND, DROUND, FINAL.
- Round key: kt = key[KEY_W-1:KEY_W-64].
- Forward key update, KEY_W=80, with constant r:
  - rotate left by 61;
  - apply S to bits [79:76];
  - XOR r into bits [19:15].
- Forward key update, KEY_W=128, with constant r:
  - rotate left by 61;
  - apply S to bits [127:124] and to bits [123:120];
  - XOR r into bits [66:62].
- Inverse key update: the exact inverse of the forward update with the same r. Steps: XOR r, then inverse S on the same nibble(s), then rotate right by 61.
- S-box: the standard PRESENT S-box, C56B90AD3EF84712.
- pLayer: bit i moves to position 16·i mod 63; bit 63 is fixed.
- IDLE with start=1:
  - load state=text_in and key=key_in;
  - encrypt: rc=1, go to EROUND;
  - decrypt: rc=1, go to KEYEXP.
- KEYEXP:
  - key <= fwd(key, rc), rc++;
  - after the cycle with rc=ROUNDS, set rc=ROUNDS and go to DROUND.
  - On exit, key holds K_(ROUNDS+1).
- EROUND:
  - state <= P(S(state ^ kt)), key <= fwd(key, rc), rc++;
  - after rc=ROUNDS, go to FINAL.
- DROUND:
  - state <= invS(invP(state ^ kt)), key <= inv(key, rc), rc--;
  - after rc=1, go to FINAL.
- FINAL: text_out <= state ^ kt, done <= 1, go to IDLE.
- start while busy is ignored; no queueing.
- decrypt and key_in changing mid-operation have no effect, since both are captured at start.
- rst in any state returns to IDLE with the reset values, and no done is issued for an aborted operation.

## Timing
- Take start as sampled at edge t.
- Encrypt: done is high and text_out valid in the cycle after edge t+ROUNDS+1. That is 32 cycles for ROUNDS=31.
- Decrypt: done after edge t+2·ROUNDS+1 (63 cycles).
- Decrypt with a key-cache hit: done after edge t+ROUNDS+1.
- ready rises in the same cycle done is high. A new start in that cycle is accepted, giving back-to-back throughput of one block per ROUNDS+2 cycles for encrypt.

## Configuration
- Macro: PRESENT_KEY_CACHE_EN.
- Defined: the core adds cache_key, cache_last (both KEY_W bits) and cache_valid.
  - On every FINAL of an encrypt, and on every exit from KEYEXP, load cache_key with the operation's key_in, load cache_last with K_(ROUNDS+1), and set cache_valid.
  - A decrypt start with cache_valid=1 and key_in==cache_key loads key=cache_last, sets rc=ROUNDS, and goes directly to DROUND.
  - rst clears cache_valid.
- Undefined: no cache logic; every decrypt runs KEYEXP.

## Test plan
- KEY_W=80, ROUNDS=31, encrypt, key=0, pt=0 -> done 32 cycles after start, text_out=5579C1387B228445.
- KEY_W=80, encrypt, key=FFFF_FFFF_FFFF_FFFF_FFFF, pt=FFFF_FFFF_FFFF_FFFF -> text_out=3333DCD3213210D2. The same key with pt=0 -> E72C46C0F5945049.
- KEY_W=80, decrypt, key=0, ct=A112FFC72F68417B -> text_out=FFFF_FFFF_FFFF_FFFF after 63 cycles. With PRESENT_KEY_CACHE_EN, repeat the request immediately -> the same result after 32 cycles.
- KEY_W=128, key=0, pt=0, encrypt -> 96DB702A2E6900AF. Decrypting that ciphertext with the same key -> 0.
- start pulsed during busy -> ignored, done count = 1. start held high continuously -> one new operation accepted per done.
- rst asserted at round 10 -> next cycle ready=1, done=0, text_out=0, and no done follows. A subsequent encrypt gives correct results, and with the cache enabled the first decrypt misses.

Source files
------------

// File: rtl/present_iter_core.sv
// present_iter_core: iterative PRESENT cipher, 80/128-bit key, one round per clock.
// Define PRESENT_KEY_CACHE_EN to keep the last expanded decrypt key.
module present_iter_core #(
  parameter int KEY_W  = 80,
  parameter int ROUNDS = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             decrypt,
  input  logic [KEY_W-1:0] key_in,
  input  logic [63:0]      text_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [63:0]      text_out
);

  localparam int         RC_LO = (KEY_W == 128) ? 62 : 15;
  localparam logic [4:0] RMAX  = 5'(ROUNDS);

  if (KEY_W != 80 && KEY_W != 128) begin : g_bad_key_w
    $error("present_iter_core: KEY_W must be 80 or 128");
  end
  if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
    $error("present_iter_core: ROUNDS must be 1..31");
  end

  typedef enum logic [2:0] {
    IDLE,
    KEYEXP,
    EROUND,
    DROUND,
    FINAL
  } state_e;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] isbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;
      4'h1: y = 4'hE;
      4'h2: y = 4'hF;
      4'h3: y = 4'h8;
      4'h4: y = 4'hC;
      4'h5: y = 4'h1;
      4'h6: y = 4'h2;
      4'h7: y = 4'hD;
      4'h8: y = 4'hB;
      4'h9: y = 4'h4;
      4'hA: y = 4'h6;
      4'hB: y = 4'h3;
      4'hC: y = 4'h0;
      4'hD: y = 4'h7;
      4'hE: y = 4'h9;
      default: y = 4'hA;
    endcase
    return y;
  endfunction

  function automatic logic [63:0] slayer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int n = 0; n < 16; n++) y[4*n +: 4] = sbox(x[4*n +: 4]);
    return y;
  endfunction

  function automatic logic [63:0] islayer(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int n = 0; n < 16; n++) y[4*n +: 4] = isbox(x[4*n +: 4]);
    return y;
  endfunction

  function automatic logic [63:0] play(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 63; i++) y[(16*i) % 63] = x[i];
    y[63] = x[63];
    return y;
  endfunction

  function automatic logic [63:0] iplay(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 63; i++) y[i] = x[(16*i) % 63];
    y[63] = x[63];
    return y;
  endfunction

  function automatic logic [KEY_W-1:0] kfwd(
    input logic [KEY_W-1:0] k,
    input logic [4:0]       r
  );
    logic [KEY_W-1:0] t;
    t = {k[KEY_W-62:0], k[KEY_W-1:KEY_W-61]};
    t[KEY_W-1 -: 4] = sbox(t[KEY_W-1 -: 4]);
    if (KEY_W == 128) t[KEY_W-5 -: 4] = sbox(t[KEY_W-5 -: 4]);
    t[RC_LO +: 5] = t[RC_LO +: 5] ^ r;
    return t;
  endfunction

  function automatic logic [KEY_W-1:0] kinv(
    input logic [KEY_W-1:0] k,
    input logic [4:0]       r
  );
    logic [KEY_W-1:0] t;
    t = k;
    t[RC_LO +: 5] = t[RC_LO +: 5] ^ r;
    t[KEY_W-1 -: 4] = isbox(t[KEY_W-1 -: 4]);
    if (KEY_W == 128) t[KEY_W-5 -: 4] = isbox(t[KEY_W-5 -: 4]);
    return {t[60:0], t[KEY_W-1:61]};
  endfunction

  state_e           fsm_q;
  logic [63:0]      st_q;
  logic [KEY_W-1:0] key_q;
  logic [4:0]       rc_q;
  logic             ready_q;
  logic             done_q;
  logic [63:0]      out_q;

  logic [63:0]      kt;
  logic [63:0]      enc_d;
  logic [63:0]      dec_d;
  logic [KEY_W-1:0] kfwd_d;
  logic [KEY_W-1:0] kinv_d;

  assign kt     = key_q[KEY_W-1 -: 64];
  assign enc_d  = play(slayer(st_q ^ kt));
  assign dec_d  = islayer(iplay(st_q ^ kt));
  assign kfwd_d = kfwd(key_q, rc_q);
  assign kinv_d = kinv(key_q, rc_q);

`ifdef PRESENT_KEY_CACHE_EN
  logic [KEY_W-1:0] ckey_q;
  logic [KEY_W-1:0] clast_q;
  logic             cvalid_q;
  logic [KEY_W-1:0] kin_q;
  logic             enc_q;
  logic             hit;

  assign hit = cvalid_q && (key_in == ckey_q);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q    <= IDLE;
      st_q     <= '0;
      key_q    <= '0;
      rc_q     <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      out_q    <= '0;
`ifdef PRESENT_KEY_CACHE_EN
      ckey_q   <= '0;
      clast_q  <= '0;
      cvalid_q <= 1'b0;
      kin_q    <= '0;
      enc_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (fsm_q)
        IDLE: begin
          if (start) begin
            st_q    <= text_in;
            key_q   <= key_in;
            rc_q    <= 5'd1;
            ready_q <= 1'b0;
            fsm_q   <= decrypt ? KEYEXP : EROUND;
`ifdef PRESENT_KEY_CACHE_EN
            kin_q   <= key_in;
            enc_q   <= ~decrypt;
            if (decrypt && hit) begin
              key_q <= clast_q;
              rc_q  <= RMAX;
              fsm_q <= DROUND;
            end
`endif
          end
        end
        KEYEXP: begin
          key_q <= kfwd_d;
          rc_q  <= rc_q + 5'd1;
          if (rc_q == RMAX) begin
            rc_q  <= RMAX;
            fsm_q <= DROUND;
`ifdef PRESENT_KEY_CACHE_EN
            ckey_q   <= kin_q;
            clast_q  <= kfwd_d;
            cvalid_q <= 1'b1;
`endif
          end
        end
        EROUND: begin
          st_q  <= enc_d;
          key_q <= kfwd_d;
          rc_q  <= rc_q + 5'd1;
          if (rc_q == RMAX) fsm_q <= FINAL;
        end
        DROUND: begin
          st_q  <= dec_d;
          key_q <= kinv_d;
          rc_q  <= rc_q - 5'd1;
          if (rc_q == 5'd1) fsm_q <= FINAL;
        end
        FINAL: begin
          out_q   <= st_q ^ kt;
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          fsm_q   <= IDLE;
`ifdef PRESENT_KEY_CACHE_EN
          // after encryption key_q already holds the last round key
          if (enc_q) begin
            ckey_q   <= kin_q;
            clast_q  <= key_q;
            cvalid_q <= 1'b1;
          end
`endif
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign ready    = ready_q;
  assign busy     = ~ready_q;
  assign done     = done_q;
  assign text_out = out_q;

endmodule
